// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types for the RAM data-port arbiter.
//   arb_state_e   : arbiter FSM states (ARB, LOCKED, YIELD)
//   arb_id_e      : requester identity (M0 = load/store unit, M1 = loader/debug)
//   arb_rsp_hdr_t : control half of the response record (valid, id). The data
//                   half is width-parameterised, so the owning module appends it.
//   other_id()    : the requester that is not the given one
// Build option: RAM_ARB_FIXED_PRIO_EN (see ram_arb_rr2).
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        YIELD  = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic    valid;
        arb_id_e id;
    } arb_rsp_hdr_t;

    function automatic arb_id_e other_id(input arb_id_e id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// ----------------------------------------------------------------------------
// ram_arb_rr2
// Two-way grant logic with a round-robin preference pointer. Requests arrive
// already masked by the arbiter FSM, so this block only resolves contention.
// The pointer names the preferred master and moves to the non-granted master
// after every grant; i_force_m0 overrides that and points it back at M0.
//
// Build option RAM_ARB_FIXED_PRIO_EN: M0 always wins on contention; the
// pointer is tied off and the clock, reset and force inputs are unused.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req0, i_req1    masked requests from M0 / M1
//   i_force_m0        point the preference at M0 at the next edge
//   o_gnt0, o_gnt1    one-hot (or zero) grant
// ----------------------------------------------------------------------------
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_force_m0,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef RAM_ARB_FIXED_PRIO_EN

    logic w_unused;

    assign o_gnt0   = i_req0;
    assign o_gnt1   = i_req1 & ~i_req0;
    assign w_unused = &{1'b0, i_clk, i_rst, i_force_m0};

`else

    arb_id_e r_rr;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt0 = (r_rr == M0);
            o_gnt1 = (r_rr == M1);
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr <= M0;
        end else if (i_force_m0) begin
            r_rr <= M0;
        end else if (o_gnt0) begin
            r_rr <= other_id(M0);
        end else if (o_gnt1) begin
            r_rr <= other_id(M1);
        end
    end

`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the RAM read/write data port between the load/store unit (m0) and the
// loader/debug master (m1). Grants are combinational from the requests; the
// read word is captured at the grant edge and returned the next cycle. m1 may
// hold the port across consecutive accesses with m1_lock_i, bounded to
// MAX_LOCK grants before a one-cycle forced yield to m0.
//
// Build option RAM_ARB_FIXED_PRIO_EN: m0 wins all contention in ARB.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mX_req_i / mX_gnt_o               request / same-cycle grant
//   mX_addr_i, mX_we_i, mX_be_i,
//   mX_wdata_i                        access payload, held until granted
//   mX_rvalid_o, mX_rdata_o           response one cycle after grant
//                                     (rdata is 0 for writes)
//   m1_lock_i                         m1 exclusive-ownership request
//   ram_en_o, ram_addr_o, ram_we_o,
//   ram_be_o, ram_wdata_o             RAM port, all zero when idle
//   ram_rdata_i                       RAM read data, combinational from address
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ARB    | normal arbitration between m0 and m1
// LOCKED | m1 owns the port; m0 blocked; lock counter tracks m1 grants
// YIELD  | one cycle after a full lock burst; m1 blocked, m0 may be granted
// ----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    input  logic                    m1_lock_i,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    typedef struct packed {
        arb_rsp_hdr_t          hdr;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;
    logic [CNT_W-1:0] w_lock_cnt_inc;
    rsp_t             r_rsp;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_force_m0;

    // Requests are masked while in reset so nothing reaches the RAM.
    assign w_req0     = m0_req_i & ~rst_i & (r_state != LOCKED);
    assign w_req1     = m1_req_i & ~rst_i & (r_state != YIELD);
    assign w_force_m0 = (r_state == YIELD);

    ram_arb_rr2 u_rr2 (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_req0     (w_req0),
        .i_req1     (w_req1),
        .i_force_m0 (w_force_m0),
        .o_gnt0     (w_gnt0),
        .o_gnt1     (w_gnt1)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign w_lock_cnt_inc = r_lock_cnt + CNT_W'(w_gnt1);

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ARB: begin
                w_lock_cnt_nxt = '0;
                if (w_gnt1 && m1_lock_i) begin
                    // A single-grant lock budget is already spent by the
                    // grant that takes the lock.
                    if (MAX_LOCK == 1) begin
                        w_state_nxt = YIELD;
                    end else begin
                        w_state_nxt    = LOCKED;
                        w_lock_cnt_nxt = CNT_ONE;
                    end
                end
            end
            LOCKED: begin
                // Lock release has priority over the budget running out.
                if (!m1_lock_i) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                end else if (w_gnt1 && (w_lock_cnt_inc == CNT_MAX)) begin
                    w_state_nxt    = YIELD;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = w_lock_cnt_inc;
                end
            end
            YIELD: begin
                w_state_nxt    = ARB;
                w_lock_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = ARB;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        m0_gnt_o    = w_gnt0;
        m1_gnt_o    = w_gnt1;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (w_gnt0) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = m0_addr_i;
            ram_we_o    = m0_we_i;
            ram_be_o    = m0_be_i;
            ram_wdata_o = m0_wdata_i;
        end else if (w_gnt1) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = m1_addr_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp <= '0;
        end else begin
            r_rsp.hdr.valid <= w_gnt0 | w_gnt1;
            r_rsp.hdr.id    <= w_gnt1 ? M1 : M0;
            r_rsp.data      <= (ram_en_o && !ram_we_o) ? ram_rdata_i : '0;
        end
    end

    // Gating with rst_i drops a response that is in flight when reset arrives.
    assign m0_rvalid_o = r_rsp.hdr.valid & (r_rsp.hdr.id == M0) & ~rst_i;
    assign m1_rvalid_o = r_rsp.hdr.valid & (r_rsp.hdr.id == M1) & ~rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? r_rsp.data : '0;
    assign m1_rdata_o  = m1_rvalid_o ? r_rsp.data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXL = 4;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req, m0_gnt, m1_gnt;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_we, m1_we;
    logic [3:0]    m0_be, m1_be;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m1_lock;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(MAXL)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .m1_lock_i(m1_lock),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM driven by the DUT's port.
    logic [DW-1:0] mem [0:255];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    // Reference model state: what the memory should hold and who owns the port.
    logic [DW-1:0] ref_mem [0:255];
    bit            md_locked, md_yield;
    int            md_burst;
    bit            md_pref_m1;
    bit            e_rv0, e_rv1;
    logic [DW-1:0] e_rd;
    bit            mg0, mg1;
    bit            dut_g0, dut_g1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit            g0, g1;
        logic [45:0]   exp_bus;
        logic [AW-1:0] a;
        logic          w;
        logic [3:0]    be;
        logic [DW-1:0] wd;
        @(negedge clk);
        g0 = 0;
        g1 = 0;
        if (!rst) begin
            if (md_yield) begin
                g0 = m0_req;
            end else if (md_locked) begin
                g1 = m1_req;
            end else if (m0_req && m1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                g0 = 1;
`else
                g0 = !md_pref_m1;
`endif
                g1 = !g0;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        chk("gnt0", 64'(m0_gnt), 64'(g0));
        chk("gnt1", 64'(m1_gnt), 64'(g1));
        exp_bus = '0;
        if (g0)      exp_bus = {1'b1, m0_addr, m0_we, m0_be, m0_wdata};
        else if (g1) exp_bus = {1'b1, m1_addr, m1_we, m1_be, m1_wdata};
        chk("ram_bus", 64'({ram_en, ram_addr, ram_we, ram_be, ram_wdata}), 64'(exp_bus));
        chk("rvalid0", 64'(m0_rvalid), 64'(e_rv0 && !rst));
        chk("rvalid1", 64'(m1_rvalid), 64'(e_rv1 && !rst));
        if (e_rv0 && !rst) chk("rdata0", 64'(m0_rdata), 64'(e_rd));
        if (e_rv1 && !rst) chk("rdata1", 64'(m1_rdata), 64'(e_rd));
        dut_g0 = m0_gnt;
        dut_g1 = m1_gnt;
        if (rst) begin
            md_locked = 0; md_yield = 0; md_burst = 0; md_pref_m1 = 0;
            e_rv0 = 0; e_rv1 = 0; e_rd = '0;
        end else begin
            e_rv0 = g0;
            e_rv1 = g1;
            e_rd  = '0;
            if (g0 || g1) begin
                a  = g0 ? m0_addr  : m1_addr;
                w  = g0 ? m0_we    : m1_we;
                be = g0 ? m0_be    : m1_be;
                wd = g0 ? m0_wdata : m1_wdata;
                if (!w) e_rd = ref_mem[a];
                else
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (md_yield) begin
                md_yield   = 0;
                md_pref_m1 = 0;
            end else if (md_locked) begin
                if (g1) begin md_burst++; md_pref_m1 = 0; end
                if (!m1_lock)              md_locked = 0;
                else if (md_burst == MAXL) begin md_locked = 0; md_yield = 1; end
            end else begin
                if (g0) md_pref_m1 = 1;
                if (g1) md_pref_m1 = 0;
                if (g1 && m1_lock) begin
                    md_burst = 1;
                    if (md_burst == MAXL) md_yield = 1;
                    else                  md_locked = 1;
                end
            end
        end
        mg0 = g0;
        mg1 = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic set_m0(input bit req, input logic [AW-1:0] a, input bit w,
                          input logic [3:0] be, input logic [DW-1:0] wd);
        m0_req = req; m0_addr = a; m0_we = w; m0_be = be; m0_wdata = wd;
    endtask

    task automatic set_m1(input bit req, input logic [AW-1:0] a, input bit w,
                          input logic [3:0] be, input logic [DW-1:0] wd);
        m1_req = req; m1_addr = a; m1_we = w; m1_be = be; m1_wdata = wd;
    endtask

    initial begin
        logic [5:0] seq;
        int         run, maxrun;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[8'h10]     = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        md_locked = 0; md_yield = 0; md_burst = 0; md_pref_m1 = 0;
        e_rv0 = 0; e_rv1 = 0; e_rd = '0; mg0 = 0; mg1 = 0;
        m1_lock = 0;
        set_m0(0, 8'h00, 0, 4'h0, '0);
        set_m1(0, 8'h00, 0, 4'h0, '0);
        do_reset();

        // Single read from m0 with m1 idle.
        set_m0(1, 8'h10, 0, 4'hF, '0);
        step();
        chk("t1_gnt", 64'(dut_g0), 64'd1);
        set_m0(0, 8'h00, 0, 4'h0, '0);
        chk("t1_rvalid", 64'(m0_rvalid), 64'd1);
        chk("t1_rdata", 64'(m0_rdata), 64'h0000_0000_DEAD_BEEF);
        step();

        // Continuous contention alternates grants, starting with m0.
        do_reset();
        set_m0(1, 8'h01, 0, 4'hF, '0);
        set_m1(1, 8'h02, 0, 4'hF, '0);
        for (int i = 0; i < 6; i++) begin
            step();
            seq[i] = dut_g1;
        end
        chk("t2_alt", 64'(seq), 64'(6'b101010));

        // Byte-enabled write by m1, then read back by m0.
        set_m0(0, 8'h00, 0, 4'h0, '0);
        set_m1(1, 8'h20, 1, 4'b0101, 32'hAABBCCDD);
        step();
        set_m1(0, 8'h00, 0, 4'h0, '0);
        set_m0(1, 8'h20, 0, 4'hF, '0);
        step();
        set_m0(0, 8'h00, 0, 4'h0, '0);
        chk("t3_rdata", 64'(m0_rdata), 64'h0000_0000_00BB_00DD);
        step();

        // Held lock: m1 burst is capped at MAXL grants, then m0 gets a turn.
        do_reset();
        m1_lock = 1;
        set_m0(1, 8'h03, 0, 4'hF, '0);
        set_m1(1, 8'h04, 0, 4'hF, '0);
        run = 0;
        maxrun = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            run = dut_g1 ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("t4_maxrun", 64'(maxrun), 64'(MAXL));

        // Lock dropped on the second locked grant; contention then goes to m0.
        do_reset();
        step();                  // m0 wins on reset preference
        step();                  // m1 wins and takes the lock
        m1_lock = 0;
        step();                  // second m1 grant, lock released
        chk("t5_m1_second", 64'(dut_g1), 64'd1);
        step();
        chk("t5_m0_after", 64'(dut_g0), 64'd1);

        // Reset the cycle after a grant drops the response and the preference.
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        chk("t6_m0_first", 64'(dut_g0), 64'd1);

        // Randomised traffic with lock toggling and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (mg0 || !m0_req)
                set_m0($urandom_range(0, 99) < 60, 8'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            if (mg1 || !m1_req)
                set_m1($urandom_range(0, 99) < 70, 8'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            if ($urandom_range(0, 99) < 15) m1_lock = ~m1_lock;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single read/write data port of the on-chip byte-enabled RAM between the core load/store unit (m0) and the program loader/debug master (m1). It sits between both masters and the RAM's data port; the instruction-fetch read port is untouched. It provides:
- req/gnt/rvalid handshakes with one-cycle registered read return;
- round-robin fairness;
- a bounded bus-lock that lets m1 perform atomic burst loads.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte address width (matches RAM)
- DATA_WIDTH, 32, data width, multiple of 8
- MAX_LOCK, 16, maximum consecutive locked m1 grants before forced yield (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- m0_req_i / m1_req_i  in  1  access request
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  byte address
- m0_we_i / m1_we_i  in  1  1 = write
- m0_be_i / m1_be_i  in  DATA_WIDTH/8  byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
- m0_rvalid_o / m1_rvalid_o  out  1  response for access granted previous cycle
- m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  read data (0 for write responses)
- m1_lock_i  in  1  m1 requests exclusive ownership across consecutive accesses
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data, combinational from ram_addr_o

## Operation
- At most one grant per cycle.
- Granted master's addr/we/be/wdata drive the RAM; ram_en_o = any grant.
- With no grant, ram_* outputs are all zero.
- Masters hold req and payload stable until gnt.
- FSM states: ARB, LOCKED, YIELD.
- ARB, arbitration:
  - Only one requester → it wins.
  - Both requesting → winner chosen by the round-robin pointer `rr`, which points at the preferred master.
  - After any grant, `rr` moves to the non-granted master.
- ARB → LOCKED when m1 is granted with m1_lock_i=1; lock counter loads 1.
- LOCKED:
  - m0 is never granted.
  - Each m1 grant increments the counter.
  - m1 idle cycles (req=0, lock=1) do not increment it.
- LOCKED → ARB when m1_lock_i=0.
- LOCKED → YIELD when the counter reaches MAX_LOCK. The grant that reaches MAX_LOCK is still honoured.
- YIELD:
  - Lasts one cycle.
  - m1 is blocked.
  - m0 is granted if requesting.
  - `rr` is forced to m0, then the FSM goes to ARB.
  - If m1_lock_i is still high, m1 may re-lock on its next ARB grant.
- Read response: ram_rdata_i is captured at the grant edge. rvalid/rdata go to the granted master the following cycle.
- Write response: rvalid with rdata = 0.
- rvalid is a single-cycle pulse per grant. Back-to-back grants give back-to-back rvalids.

## Timing
- Grant is combinational from req in the same cycle; the RAM write commits at that clock edge.
- Read latency: 1 cycle, gnt cycle N → rvalid cycle N+1.
- Reset state:
  - FSM = ARB, `rr` = m0, counter = 0.
  - All rvalid = 0, all rdata = 0, no gnt.
- Reset mid-access: an in-flight rvalid is dropped, and a locked m1 loses the lock.
- Simultaneous m1 lock drop and counter = MAX_LOCK: lock drop wins, next state is ARB.
- Write then read to the same address in consecutive cycles: the read returns the new data.

## Configuration
- RAM_ARB_FIXED_PRIO_EN:
  - Defined: in ARB, m0 always wins on contention and `rr` is unused (tied off). LOCKED/YIELD behaviour is unchanged, so m1 starvation is bounded only when m0 idles.
  - Undefined: round-robin as above.

## Structure
- Package ram_arb_pkg:
  - state enum `arb_state_e` {ARB, LOCKED, YIELD};
  - requester-id typedef `arb_id_e` {M0, M1};
  - response-record typedef (valid, id, data).
- Lock counter width: $clog2(MAX_LOCK+1), derived locally.
- Sub-module ram_arb_rr2: 2-way grant logic plus `rr` pointer, with the FIXED_PRIO variant inside.

## Test plan
- m0 read addr 0x10, m1 idle, mem[0x10]=0xDEADBEEF → m0_gnt_o same cycle; m0_rvalid_o=1 with rdata 0xDEADBEEF next cycle.
- Both request continuously after reset → grants alternate m0, m1, m0, m1; each rvalid reaches the correct master one cycle later.
- m1 writes 0xAABBCCDD to 0x20 with be=4'b0101, then m0 reads 0x20 from prior 0 → m0 rdata 0x00BB00DD.
- m1_lock_i held, m1 requesting every cycle, m0 requesting, MAX_LOCK=4 → m1 granted 4 times, YIELD cycle grants m0, then m1 may re-lock.
- m1 drops lock after 2 grants → next cycle ARB; with both requesting, `rr`=m0 so m0 is granted.
- rst_i asserted the cycle after a grant → no rvalid next cycle; state ARB; the first grant after reset goes to m0 on contention.
